// File: rtl/bus_arbiter_if.sv
// Memory-style bus used by both requesters and the shared memory port.
// The master modport drives the command; the slave modport answers it.
interface bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;
    logic                  err;

    modport master (
        output addr, wdata, read, write,
        input  rdata, ready, err
    );

    modport slave (
        input  addr, wdata, read, write,
        output rdata, ready, err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single data-memory bus.
// Optional response timeout is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    bus_arbiter_if.slave         m0,
    bus_arbiter_if.slave         m1,
    bus_arbiter_if.master        mem,
    output logic [1:0]           grant
);
    typedef enum logic {StIdle, StBusy} state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;

    logic                  req0, req1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_read, sel_write, sel_req;
    logic                  busy, fwd, done, abort, timeout, rsp;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    assign sel_addr  = owner_q ? m1.addr  : m0.addr;
    assign sel_wdata = owner_q ? m1.wdata : m0.wdata;
    assign sel_read  = owner_q ? m1.read  : m0.read;
    assign sel_write = owner_q ? m1.write : m0.write;
    assign sel_req   = sel_read | sel_write;

    // Reset masks the bus in its own cycle so a mid-transfer reset never completes.
    assign busy  = (state_q == StBusy) && !reset;
    assign fwd   = busy && sel_req;
    assign done  = busy && mem.ready;
    assign abort = busy && !mem.ready && !sel_req;
    assign rsp   = done || timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 5) ? $clog2(TIMEOUT_CYCLES) : 5;

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    assign timeout = busy && !mem.ready && sel_req &&
                     (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == StIdle) begin
            wait_cnt_d = '0;
        end else if (!mem.ready) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    logic unused_mem_err;
    assign unused_mem_err = mem.err;

    // Write wins when a master raises both strobes.
    assign mem.addr  = fwd ? sel_addr  : '0;
    assign mem.wdata = fwd ? sel_wdata : '0;
    assign mem.write = fwd && sel_write;
    assign mem.read  = fwd && sel_read && !sel_write;

    assign rsp_rdata = done ? mem.rdata : '0;

    assign m0.ready = rsp && !owner_q;
    assign m0.err   = timeout && !owner_q;
    assign m0.rdata = !owner_q ? rsp_rdata : '0;
    assign m1.ready = rsp && owner_q;
    assign m1.err   = timeout && owner_q;
    assign m1.rdata = owner_q ? rsp_rdata : '0;

    assign grant = {(state_q == StBusy) && owner_q, (state_q == StBusy) && !owner_q};

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StBusy;
                    owner_d = (req0 && req1) ? !last_q : req1;
                end
            end
            StBusy: begin
                if (rsp) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                end else if (abort) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_bus_arbiter;
    localparam int unsigned Tmo = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;

    bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
    bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
    bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    bus_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clock(clk),
        .reset(rst),
        .m0(m0_bus),
        .m1(m1_bus),
        .mem(mem_bus),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: who holds the bus, who was served last, how long it has waited.
    bit m_busy = 1'b0;
    int m_own  = 0;
    int m_last = 1;
    int m_cnt  = 0;

    // Values seen in the most recent step, for directed checks.
    logic [1:0]  obs_grant;
    logic        obs_rdy[2];
    logic        obs_err[2];
    logic [31:0] obs_rdata[2];
    logic        obs_mr, obs_mw;
    logic [31:0] obs_addr, obs_wdata;
    bit          exp_rdy[2];

    task automatic set_m(input int i, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] w);
        if (i == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.addr = a; m0_bus.wdata = w;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.addr = a; m1_bus.wdata = w;
        end
    endtask

    task automatic set_mem(input bit rdy, input logic [31:0] d);
        mem_bus.ready = rdy;
        mem_bus.rdata = d;
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit          rd[2], wr[2], req, tmo, resp, mr, r;
        logic [31:0] ad[2], wd[2], mrd;
        bit          e_mr, e_mw;
        logic [31:0] e_addr, e_wdata;
        bit          e_rdy[2], e_err[2];
        logic [31:0] e_rdata[2];
        logic [1:0]  e_grant;

        @(negedge clk);
        #1;
        rd[0] = m0_bus.read;  wr[0] = m0_bus.write; ad[0] = m0_bus.addr; wd[0] = m0_bus.wdata;
        rd[1] = m1_bus.read;  wr[1] = m1_bus.write; ad[1] = m1_bus.addr; wd[1] = m1_bus.wdata;
        mr = mem_bus.ready; mrd = mem_bus.rdata; r = rst;

        e_mr = 0; e_mw = 0; e_addr = 0; e_wdata = 0; req = 0; tmo = 0; resp = 0;
        for (int i = 0; i < 2; i++) begin
            e_rdy[i] = 0; e_err[i] = 0; e_rdata[i] = 0;
        end
        e_grant = m_busy ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00;
        if (m_busy && !r) begin
            req = rd[m_own] || wr[m_own];
            if (req) begin
                e_mw = wr[m_own];
                e_mr = rd[m_own] && !wr[m_own];
                e_addr = ad[m_own];
                e_wdata = wd[m_own];
            end
            tmo  = TmoEn && !mr && req && (m_cnt == Tmo - 1);
            resp = mr || tmo;
            e_rdy[m_own]   = resp;
            e_err[m_own]   = tmo;
            e_rdata[m_own] = mr ? mrd : 32'h0;
        end

        check_eq("grant", 64'(grant), 64'(e_grant));
        check_eq("mem_read", 64'(mem_bus.read), 64'(e_mr));
        check_eq("mem_write", 64'(mem_bus.write), 64'(e_mw));
        check_eq("mem_addr", 64'(mem_bus.addr), 64'(e_addr));
        check_eq("mem_wdata", 64'(mem_bus.wdata), 64'(e_wdata));
        check_eq("m0_ready", 64'(m0_bus.ready), 64'(e_rdy[0]));
        check_eq("m1_ready", 64'(m1_bus.ready), 64'(e_rdy[1]));
        check_eq("m0_err", 64'(m0_bus.err), 64'(e_err[0]));
        check_eq("m1_err", 64'(m1_bus.err), 64'(e_err[1]));
        check_eq("m0_rdata", 64'(m0_bus.rdata), 64'(e_rdata[0]));
        check_eq("m1_rdata", 64'(m1_bus.rdata), 64'(e_rdata[1]));

        obs_grant = grant;
        obs_rdy[0] = m0_bus.ready;  obs_rdy[1] = m1_bus.ready;
        obs_err[0] = m0_bus.err;    obs_err[1] = m1_bus.err;
        obs_rdata[0] = m0_bus.rdata; obs_rdata[1] = m1_bus.rdata;
        obs_mr = mem_bus.read; obs_mw = mem_bus.write;
        obs_addr = mem_bus.addr; obs_wdata = mem_bus.wdata;
        exp_rdy = e_rdy;

        @(posedge clk);
        if (r) begin
            m_busy = 0; m_last = 1; m_cnt = 0;
        end else if (!m_busy) begin
            if ((rd[0] || wr[0]) && (rd[1] || wr[1])) begin
                m_own = 1 - m_last; m_busy = 1; m_cnt = 0;
            end else if (rd[0] || wr[0]) begin
                m_own = 0; m_busy = 1; m_cnt = 0;
            end else if (rd[1] || wr[1]) begin
                m_own = 1; m_busy = 1; m_cnt = 0;
            end
        end else if (resp) begin
            m_last = m_own; m_busy = 0;
        end else if (!req) begin
            m_busy = 0;
        end else begin
            m_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int          cnt_a, cnt_b, first;
    logic [31:0] seen;
    bit          act[2];
    logic [1:0]  alt_exp[8];

    initial begin
        set_m(0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0);
        set_mem(0, 0);
        mem_bus.err = 1'b0;
        do_reset();
        check_eq("reset_grant", 64'(obs_grant), 64'(2'b00));
        check_eq("reset_mem_read", 64'(obs_mr), 64'(0));

        // Single read on master 0.
        set_m(0, 1, 0, 32'h100, 0);
        step();
        step();
        check_eq("t1_grant", 64'(obs_grant), 64'(2'b01));
        check_eq("t1_strobe", 64'(obs_mr), 64'(1));
        check_eq("t1_addr", 64'(obs_addr), 64'(32'h100));
        set_mem(1, 32'hCAFEF00D);
        cnt_a = 0; cnt_b = 0; seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (obs_rdy[0]) begin cnt_a++; seen = obs_rdata[0]; set_m(0, 0, 0, 0, 0); end
            if (obs_rdy[1]) cnt_b++;
        end
        check_eq("t1_m0_pulses", 64'(cnt_a), 64'(1));
        check_eq("t1_m0_rdata", 64'(seen), 64'(32'hCAFEF00D));
        check_eq("t1_m1_pulses", 64'(cnt_b), 64'(0));

        // Continuous contention alternates starting with master 0.
        do_reset();
        set_m(0, 0, 1, 32'h40, 32'h1111);
        set_m(1, 1, 0, 32'h80, 0);
        set_mem(1, 32'h2222);
        alt_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq($sformatf("t2_grant%0d", i), 64'(obs_grant), 64'(alt_exp[i]));
        end

        // Write wins over read on master 1.
        do_reset();
        set_m(0, 0, 0, 0, 0);
        set_m(1, 1, 1, 32'h20, 32'h55);
        set_mem(0, 0);
        step();
        step();
        check_eq("t3_mem_write", 64'(obs_mw), 64'(1));
        check_eq("t3_mem_read", 64'(obs_mr), 64'(0));
        check_eq("t3_mem_addr", 64'(obs_addr), 64'(32'h20));
        check_eq("t3_mem_wdata", 64'(obs_wdata), 64'(32'h55));
        set_mem(1, 32'h9);
        step();
        set_m(1, 0, 0, 0, 0);
        set_mem(0, 0);
        step();

        // Withdrawn request aborts without ready; next tie still goes to master 0.
        do_reset();
        set_m(0, 1, 0, 32'h300, 0);
        step();
        step();
        set_m(0, 0, 0, 0, 0);
        step();
        check_eq("t4_strobe_drop", 64'(obs_mr), 64'(0));
        check_eq("t4_no_ready", 64'(obs_rdy[0]), 64'(0));
        set_m(0, 1, 0, 32'h304, 0);
        set_m(1, 1, 0, 32'h308, 0);
        step();
        check_eq("t4_idle", 64'(obs_grant), 64'(2'b00));
        step();
        check_eq("t4_tie_m0", 64'(obs_grant), 64'(2'b01));
        set_m(0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0);
        step();
        step();

        // Reset while master 1 is busy.
        do_reset();
        set_m(1, 1, 0, 32'h500, 0);
        step();
        step();
        check_eq("t5_busy_m1", 64'(obs_grant), 64'(2'b10));
        set_mem(1, 32'h77);
        rst = 1'b1;
        step();
        check_eq("t5_no_ready", 64'(obs_rdy[1]), 64'(0));
        rst = 1'b0;
        set_m(1, 0, 0, 0, 0);
        set_mem(0, 0);
        step();
        check_eq("t5_grant_idle", 64'(obs_grant), 64'(2'b00));
        check_eq("t5_strobe_off", 64'(obs_mr), 64'(0));

        // Memory never answers: timeout pulse or endless wait.
        do_reset();
        set_m(0, 1, 0, 32'h600, 0);
        set_mem(0, 32'hDEAD);
        first = -1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (obs_rdy[0] && first < 0) begin
                first = i;
                check_eq("t6_err", 64'(obs_err[0]), 64'(1));
                check_eq("t6_rdata", 64'(obs_rdata[0]), 64'(0));
            end
        end
        check_eq("t6_first_pulse", 64'(first), TmoEn ? 64'(16) : 64'(-1));
        set_m(0, 0, 0, 0, 0);

        // Random traffic against the model.
        do_reset();
        act[0] = 0; act[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_mem($urandom_range(0, 2) == 0, $urandom);
            for (int i = 0; i < 2; i++) begin
                if (act[i] && (exp_rdy[i] || $urandom_range(0, 59) == 0)) begin
                    act[i] = 0;
                    set_m(i, 0, 0, 0, 0);
                end else if (!act[i] && $urandom_range(0, 2) == 0) begin
                    act[i] = 1;
                    case ($urandom_range(0, 2))
                        0: set_m(i, 1, 0, $urandom, $urandom);
                        1: set_m(i, 0, 1, $urandom, $urandom);
                        default: set_m(i, 1, 1, $urandom, $urandom);
                    endcase
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
